// File: rtl/i2c_target_pkg.sv
// Shared encodings and constants for the I2C register target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam int         REG_COUNT = 16;
  // First read-only (status) register index.
  localparam logic [3:0] RO_BASE   = 4'hC;
  localparam logic       ACK       = 1'b0;
  localparam logic       NACK      = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  // Fewer than two flops would not resolve metastability.
  localparam int STG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STG-1:0] scl_sync, sda_sync;
  logic           scl_s, scl_d, sda_d;
  // Fills with ones after reset; events are suppressed until the
  // synchronizers and the delay flop all hold real pad samples.
  logic [STG:0]   vld_pipe;
  logic           vld;

  // Synchronizer chains, one-cycle delayed copy and warm-up pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      vld_pipe <= '0;
    end else begin
      scl_sync <= {scl_sync[STG-2:0], scl_i};
      sda_sync <= {sda_sync[STG-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      vld_pipe <= {vld_pipe[STG-1:0], 1'b1};
    end
  end

  assign scl_s     = scl_sync[STG-1];
  assign sda_s     = sda_sync[STG-1];
  assign vld       = vld_pipe[STG];
  assign scl_rise  = vld &  scl_s & ~scl_d;
  assign scl_fall  = vld & ~scl_s &  scl_d;
  assign start_det = vld &  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  = vld &  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing 12 control registers and 4 status registers.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [95:0] ctrl_regs,
  input  logic [31:0] status_in,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                     state, state_n;
  logic [3:0]                 cnt, cnt_n;
  logic [7:0]                 shreg, shreg_n;
  logic [3:0]                 ptr, ptr_n;
  logic                       sda_oe_n, busy_n;
  logic                       wr_stb_n, wr_en;
  logic [3:0]                 wr_addr_n;
  logic [7:0]                 wr_data_n;
  logic [7:0]                 rx_byte, rd_byte;
  logic [11:0][7:0]           ctrl_q;
  logic [REG_COUNT-1:0][7:0]  reg_view;

  // Unified 16-entry read view: control bytes low, status bytes high.
  assign reg_view  = {status_in, ctrl_q};
  assign ctrl_regs = ctrl_q;
  assign dbg_state = state;

  // State and datapath registers; control bytes written on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ctrl_q    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= wr_stb_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      for (int i = 0; i < 12; i++)
        if (wr_en && (wr_addr_n == 4'(i))) ctrl_q[i] <= wr_data_n;
    end
  end

  // Next-state and output decode; bus conditions override bit events.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    wr_en     = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rx_byte   = {shreg[6:0], sda_s};
    rd_byte   = reg_view[ptr];

    if (start_det) begin
      state_n  = ST_ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shreg_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (rx_byte[7:1] == ADDR) begin
              state_n = ST_ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end

        // shreg still holds the address byte, so bit 0 is R/W.
        // sda_oe doubles as the ACK phase flag: first fall drives, second releases.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = ~ACK;
          end else if (shreg[0]) begin
            state_n  = ST_RDATA;
            shreg_n  = rd_byte;
            sda_oe_n = ~rd_byte[7];
            cnt_n    = '0;
          end else begin
            state_n  = ST_PTR;
            sda_oe_n = 1'b0;
            cnt_n    = '0;
          end
        end

        ST_PTR: if (scl_rise) begin
          shreg_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            ptr_n   = rx_byte[3:0];
            state_n = ST_PTR_ACK;
            cnt_n   = '0;
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = ~ACK;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = ST_WDATA;
            cnt_n    = '0;
          end
        end

        // Status registers accept the byte on the bus but discard it.
        ST_WDATA: if (scl_rise) begin
          shreg_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (ptr < RO_BASE) begin
              wr_en     = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = rx_byte;
            end
            ptr_n   = ptr + 4'd1;
            state_n = ST_WDATA_ACK;
            cnt_n   = '0;
          end
        end

        // cnt counts bits the controller has sampled; bit 7 was driven on load.
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = ST_RDATA_ACK;
              cnt_n    = '0;
            end else if (cnt != 4'd0) begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end

        // cnt==1 marks an ACK seen; the next byte loads on the following fall.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end else begin
              ptr_n = ptr + 4'd1;
              cnt_n = 4'd1;
            end
          end else if (scl_fall && (cnt == 4'd1)) begin
            state_n  = ST_RDATA;
            shreg_n  = rd_byte;
            sda_oe_n = ~rd_byte[7];
            cnt_n    = '0;
          end
        end

        ST_IGNORE: sda_oe_n = 1'b0;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C controller against the register target.
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl, sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [95:0] ctrl_regs;
  logic [31:0] status_in;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [3:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  int          hi_chg = 0;
  int          oe_cnt = 0;
  logic        prev_oe = 1'b0;
  logic [11:0] stb_q[$];
  logic [11:0][7:0] exp_ctrl;
  logic        ack;
  logic [7:0]  rb;

  // Open-drain SDA: controller and target both pull low.
  assign sda_line = sda_m & ~sda_oe;

  always #15 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .ctrl_regs (ctrl_regs),
    .status_in (status_in),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quarter-period wait that also watches sda_oe and wr_strobe.
  task automatic tq();
    repeat (Q) begin
      @(posedge clk); #1;
      if (scl && (sda_oe !== prev_oe)) hi_chg++;
      prev_oe = sda_oe;
      if (sda_oe === 1'b1) oe_cnt++;
      if (wr_strobe === 1'b1) stb_q.push_back({wr_addr, wr_data});
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tq(); scl = 1'b1; tq(); sda_m = 1'b0; tq(); scl = 1'b0; tq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tq(); scl = 1'b1; tq(); sda_m = 1'b1; tq();
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    sda_m = b; tq(); scl = 1'b1; tq(); smp = sda_line; tq(); scl = 1'b0; tq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nack, s);
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; status_in = 32'hDEADBEEF;
    exp_ctrl = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ctrl", ctrl_regs, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tq();

    // Write 0xA5, 0x5A starting at register 3.
    i2c_start();
    write_byte(8'h90, ack); check("t1_addr_ack", ack, 1);
    check("t1_busy", busy, 1);
    write_byte(8'h03, ack); check("t1_ptr_ack", ack, 1);
    write_byte(8'hA5, ack); check("t1_d0_ack", ack, 1);
    write_byte(8'h5A, ack); check("t1_d1_ack", ack, 1);
    i2c_stop(); tq();
    exp_ctrl[3] = 8'hA5; exp_ctrl[4] = 8'h5A;
    check("t1_nstb", stb_q.size(), 2);
    check("t1_stb0", stb_q[0], 12'h3A5);
    check("t1_stb1", stb_q[1], 12'h45A);
    check("t1_ctrl", ctrl_regs, exp_ctrl);
    check("t1_busy_end", busy, 0);
    check("t1_state_end", dbg_state, ST_IDLE);

    // Pointer write, repeated START, read two bytes back.
    i2c_start();
    write_byte(8'h90, ack); check("t2_addr_ack", ack, 1);
    write_byte(8'h03, ack); check("t2_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h91, ack); check("t2_raddr_ack", ack, 1);
    read_byte(1'b0, rb); check("t2_rd0", rb, 8'hA5);
    read_byte(1'b1, rb); check("t2_rd1", rb, 8'h5A);
    check("t2_oe_nack", sda_oe, 0);
    check("t2_busy_nack", busy, 0);
    check("t2_state_nack", dbg_state, ST_IGNORE);
    i2c_stop(); tq();
    check("t2_nstb", stb_q.size(), 2);

    // Wrong address: no ACK, ignore until STOP.
    oe_cnt = 0;
    i2c_start();
    write_byte(8'h92, ack); check("t3_addr_nack", ack, 0);
    check("t3_state", dbg_state, ST_IGNORE);
    write_byte(8'h00, ack); check("t3_data_nack", ack, 0);
    check("t3_oe_cycles", oe_cnt, 0);
    check("t3_busy", busy, 0);
    i2c_stop(); tq();
    check("t3_state_end", dbg_state, ST_IDLE);
    check("t3_nstb", stb_q.size(), 2);

    // Status read from 0x0E with pointer wrap into register 0.
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h0E, ack); check("t4_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h91, ack); check("t4_raddr_ack", ack, 1);
    read_byte(1'b0, rb); check("t4_rd_0e", rb, 8'hAD);
    read_byte(1'b0, rb); check("t4_rd_0f", rb, 8'hDE);
    read_byte(1'b1, rb); check("t4_rd_wrap", rb, 8'h00);
    i2c_stop(); tq();
    // Write to read-only 0x0D: ACKed, dropped.
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h0D, ack);
    write_byte(8'h77, ack); check("t4_ro_ack", ack, 1);
    i2c_stop(); tq();
    check("t4_ro_nstb", stb_q.size(), 2);
    check("t4_ro_ctrl", ctrl_regs, exp_ctrl);
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h0D, ack);
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(1'b1, rb); check("t4_rd_0d", rb, 8'hBE);
    i2c_stop(); tq();

    // STOP after 4 data bits: partial byte dropped.
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h05, ack);
    clk_bit(1'b1, ack); clk_bit(1'b0, ack); clk_bit(1'b1, ack); clk_bit(1'b1, ack);
    i2c_stop(); tq();
    check("t5_nstb", stb_q.size(), 2);
    check("t5_ctrl", ctrl_regs, exp_ctrl);
    check("t5_state", dbg_state, ST_IDLE);
    i2c_start();
    write_byte(8'h90, ack); check("t5_next_ack", ack, 1);
    write_byte(8'h05, ack);
    write_byte(8'h3C, ack); check("t5_data_ack", ack, 1);
    i2c_stop(); tq();
    exp_ctrl[5] = 8'h3C;
    check("t5_nstb2", stb_q.size(), 3);
    check("t5_stb", stb_q[2], 12'h53C);
    check("t5_ctrl2", ctrl_regs, exp_ctrl);

    // Reset while the target drives a 0 data bit (0x3C bit 7).
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'h91, ack); check("t6_raddr_ack", ack, 1);
    check("t6_driving", sda_oe, 1);
    check("t6_state_rd", dbg_state, ST_RDATA);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_oe_rst", sda_oe, 0);
    check("t6_state_rst", dbg_state, ST_IDLE);
    check("t6_busy_rst", busy, 0);
    check("t6_ctrl_rst", ctrl_regs, 0);
    check("t6_stb_rst", wr_strobe, 0);
    check("t6_waddr_rst", wr_addr, 0);
    check("t6_wdata_rst", wr_data, 0);
    rst = 1'b0;
    exp_ctrl = '0;
    prev_oe = sda_oe;
    tq();
    i2c_start();
    write_byte(8'h90, ack); check("t6_after_ack", ack, 1);
    write_byte(8'h01, ack); check("t6_after_ptr", ack, 1);
    i2c_stop(); tq();
    check("t6_state_end", dbg_state, ST_IDLE);

    check("oe_change_scl_high", hi_chg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Synthesizable I2C target (responder) that presents a 16-byte register file to an external I2C controller on a 7-bit address. It is the bus-side counterpart of the FPGA's controller-side PMIC link: it lets the host MCU, or a bench-side PMIC model, configure the design over I2C. It runs on the 33 MHz system clock and oversamples SCL/SDA, so there is no SCL clock domain.

Parameters:
ADDR, 7'h48, 7-bit target address matched after START
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2)

Ports:
clk  in  1  system clock, 33 MHz
rst  in  1  synchronous active-high reset
scl_i  in  1  SCL pad input (asynchronous)
sda_i  in  1  SDA pad input (asynchronous)
sda_oe  out  1  1 = pull SDA low (open-drain); top level ties pad to 0 when set, Z otherwise
ctrl_regs  out  96  registers 0x00-0x0B; reg n occupies bits [8n+7:8n]
status_in  in  32  read-only registers 0x0C-0x0F; reg 0x0C+k = status_in[8k+7:8k], sampled on byte load
wr_strobe  out  1  one-cycle pulse when a data byte is committed to 0x00-0x0B
wr_addr  out  4  register index for wr_strobe
wr_data  out  8  byte for wr_strobe
busy  out  1  1 from addressed START (match) until STOP/START/NACK release
dbg_state  out  4  current FSM state encoding

Behaviour:
- Reset: sda_oe=0, ctrl_regs=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, pointer=0, state=IDLE. Reset mid-transfer releases SDA the next cycle; the bus is ignored until the next START.
- Input conditioning: SYNC_STAGES flops, then a 1-cycle-delayed copy for edge detection. Detected events are scl_rise, scl_fall, START (SDA falls while SCL high) and STOP (SDA rises while SCL high).
- SDA is sampled on scl_rise. sda_oe changes only on the cycle after scl_fall. It never changes while SCL is high.
- START or STOP in any state has priority over bit events. START -> ADDR with bit counter cleared and sda_oe=0. STOP -> IDLE with sda_oe=0 and busy=0.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: shift 8 bits, MSB first. On the 8th scl_rise: if [7:1]==ADDR, go to ADDR_ACK and set busy=1; otherwise go to IGNORE with no ACK. General call (0x00) is not matched.
  - ADDR_ACK: drive sda_oe=1 from the scl_fall after bit 8 until the scl_fall after bit 9. Then R/W=0 -> PTR; R/W=1 -> RDATA with shift register loaded from reg[pointer] and bit 7 driven immediately.
  - PTR: 8 bits received; pointer <= byte[3:0] (bits [7:4] ignored); ACK -> WDATA.
  - WDATA: 8 bits received, then ACK. If pointer<=0x0B, write the register and pulse wr_strobe for 1 cycle on the 8th scl_rise. Writes to 0x0C-0x0F are ACKed and discarded, with no strobe. pointer <= pointer+1 mod 16 (0x0F wraps to 0x00). Return to WDATA.
  - RDATA: drive each bit on scl_fall; sda_oe = ~bit. After 8 bits, release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample the controller ACK on scl_rise. ACK (0) -> pointer+1 mod 16, load the next byte, go to RDATA. NACK (1) -> IGNORE with busy=0.
  - IGNORE: sda_oe=0; wait for START or STOP.
- A repeated START after PTR sets up a read from the new pointer; the pointer persists across transactions until reset.
- A STOP or START mid-byte discards the partial byte: no register write, no strobe.
- ctrl_regs is updated in the same cycle as wr_strobe. status_in is captured only on byte load, so it is stable during the shift.

Decomposition:
- Package i2c_target_pkg: FSM state encoding constants, REG_COUNT=16, RO_BASE=4'hC, ACK/NACK bit constants.
- Sub-module i2c_bus_cond: synchronizer plus edge/START/STOP detector. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Write 0x48/W, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on every byte; wr_strobe twice (addr 3/0xA5, addr 4/0x5A); ctrl_regs[31:24]=0xA5, [39:32]=0x5A.
- ptr 0x03 write, repeated START, 0x48/R, read 2 bytes (ACK, NACK), STOP -> returns 0xA5, 0x5A; sda_oe=0 after NACK; busy=0.
- Address 0x49/W -> no ACK (sda_oe stays 0 for the whole frame), no strobe, state IGNORE until STOP.
- status_in=0xDEADBEEF, read from ptr 0x0E for 3 bytes -> 0xAD, 0xDE, then reg 0x00 (pointer wrap); write to 0x0D -> ACKed, no strobe, status readback unchanged.
- STOP after 4 data bits of a write -> no strobe, register unchanged; the next transaction works normally.
- rst asserted during RDATA while driving 0 -> sda_oe=0 the next cycle, all outputs at reset values, the next frame ACKs normally.
